// File: rtl/keccak_byte_packer.sv
// rtl/keccak_byte_packer.sv - packs a byte stream into 32-bit keccak input words with end-of-message padding
module keccak_byte_packer #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        buffer_full,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        word_last,
    output logic [1:0]  word_byte_num,
    output logic        msg_done
);

    // Partial word being assembled and number of lanes already filled
    logic [31:0] acc;
    logic [1:0]  cnt;

    // A full final word was emitted; the core still needs an all-zero last word
    logic        pad_pending;

    logic        take_out;
    logic        accept;
    logic        completes_word;
    logic        complete;
    logic        load_pad;
    logic [4:0]  lane_shift;
    logic [31:0] merged;

    // Handshake decode: output register consumption, byte acceptance and word completion
    always_comb begin
        take_out       = word_valid && !buffer_full;
        completes_word = (cnt == 2'd3) || s_last;
        // Stall only a byte that would need the output register while it is still occupied;
        // non-completing bytes keep filling acc while the previous word waits.
        s_ready        = !reset && !pad_pending && !(word_valid && !take_out && completes_word);
        accept         = s_valid && s_ready;
        complete       = accept && completes_word;
        load_pad       = pad_pending && (!word_valid || take_out);
    end

    // Lane placement of the incoming byte, merged with the lanes already held
    always_comb begin
        lane_shift = 5'd0;
        if (BIG_ENDIAN) begin
            lane_shift = 5'd24 - {cnt, 3'b000};
        end else begin
            lane_shift = {cnt, 3'b000};
        end
        merged = acc | (32'(s_data) << lane_shift);
    end

    // Accumulator: collect bytes, restart empty after every completed word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= 32'd0;
            cnt <= 2'd0;
        end else if (accept) begin
            if (completes_word) begin
                acc <= 32'd0;
                cnt <= 2'd0;
            end else begin
                acc <= merged;
                cnt <= cnt + 2'd1;
            end
        end
    end

    // Output register: data word has priority, then the pad word, else drain on take
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out      <= 32'd0;
            word_valid    <= 1'b0;
            word_last     <= 1'b0;
            word_byte_num <= 2'd0;
        end else if (complete) begin
            word_out   <= merged;
            word_valid <= 1'b1;
            if (s_last && (cnt != 2'd3)) begin
                // Short final word: core uses byte_num to know how many lanes are real
                word_last     <= 1'b1;
                word_byte_num <= cnt + 2'd1;
            end else begin
                // Full word; if it ends the message the pad word follows
                word_last     <= 1'b0;
                word_byte_num <= 2'd0;
            end
        end else if (load_pad) begin
            word_out      <= 32'd0;
            word_valid    <= 1'b1;
            word_last     <= 1'b1;
            word_byte_num <= 2'd0;
        end else if (take_out) begin
            word_valid <= 1'b0;
        end
    end

    // Pad request: set by a message ending on a word boundary, cleared when the pad loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_pending <= 1'b0;
        end else if (complete && s_last && (cnt == 2'd3)) begin
            pad_pending <= 1'b1;
        end else if (load_pad) begin
            pad_pending <= 1'b0;
        end
    end

    // End-of-message pulse, one cycle after the final word is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_done <= 1'b0;
        end else begin
            msg_done <= take_out && word_last;
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb/tb_keccak_byte_packer.sv - scoreboard bench for keccak_byte_packer
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready, buffer_full;
    logic [31:0] word_out;
    logic        word_valid, word_last, msg_done;
    logic [1:0]  word_byte_num;

    logic        s_valid_le, s_ready_le, word_valid_le, word_last_le, msg_done_le;
    logic [31:0] word_out_le;
    logic [1:0]  word_byte_num_le;

    typedef struct {
        logic [31:0] w;
        logic        l;
        logic [1:0]  n;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   le_words = 0;
    int   le_dones = 0;
    bit   le_en = 1'b0;

    always #5 clk = ~clk;

    keccak_byte_packer #(.BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .buffer_full(buffer_full), .word_out(word_out),
        .word_valid(word_valid), .word_last(word_last), .word_byte_num(word_byte_num),
        .msg_done(msg_done)
    );

    keccak_byte_packer #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_le), .s_last(s_last),
        .s_ready(s_ready_le), .buffer_full(buffer_full), .word_out(word_out_le),
        .word_valid(word_valid_le), .word_last(word_last_le), .word_byte_num(word_byte_num_le),
        .msg_done(msg_done_le)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input logic l, input logic [1:0] n);
        exp_t e;
        e.w = w;
        e.l = l;
        e.n = n;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            int  t;
            bit  done;
            s_data     = s[i];
            s_last     = with_last && (i == s.len() - 1);
            s_valid    = 1'b1;
            s_valid_le = le_en;
            t    = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (s_ready && (!le_en || s_ready_le)) begin
                    done = 1'b1;
                end else if (t > 200) begin
                    errors++;
                    checks++;
                    $display("FAIL accept_timeout byte=%0d actual=stalled required=accepted", i);
                    done = 1'b1;
                end
                t++;
                @(posedge clk);
                #1;
            end
        end
        s_valid    = 1'b0;
        s_valid_le = 1'b0;
        s_last     = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every consumed word, checks hold stability and msg_done
    initial begin : monitor
        logic        exp_done;
        logic        hold_v;
        logic [31:0] hold_w;
        logic        hold_l;
        logic [1:0]  hold_n;
        exp_t        e;
        exp_done = 1'b0;
        hold_v   = 1'b0;
        hold_w   = 32'd0;
        hold_l   = 1'b0;
        hold_n   = 2'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_done = 1'b0;
                hold_v   = 1'b0;
            end else begin
                check("msg_done", 32'(msg_done), 32'(exp_done));
                if (hold_v && word_valid) begin
                    check("hold_word", word_out, hold_w);
                    check("hold_last", 32'(word_last), 32'(hold_l));
                    check("hold_byte_num", 32'(word_byte_num), 32'(hold_n));
                end
                hold_v = word_valid && buffer_full;
                hold_w = word_out;
                hold_l = word_last;
                hold_n = word_byte_num;
                if (word_valid && !buffer_full) begin
                    if (sb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_word actual=%h required=none", word_out);
                    end else begin
                        e = sb.pop_front();
                        check("word_out", word_out, e.w);
                        check("word_last", 32'(word_last), 32'(e.l));
                        check("word_byte_num", 32'(word_byte_num), 32'(e.n));
                    end
                end
                exp_done = word_valid && !buffer_full && word_last;
                if (word_valid_le && !buffer_full) begin
                    check("le_word_out", word_out_le, 32'h0000_0021);
                    check("le_word_last", 32'(word_last_le), 32'd1);
                    check("le_byte_num", 32'(word_byte_num_le), 32'd1);
                    le_words++;
                end
                if (msg_done_le) le_dones++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset       = 1'b1;
        s_data      = 8'd0;
        s_valid     = 1'b0;
        s_valid_le  = 1'b0;
        s_last      = 1'b0;
        buffer_full = 1'b0;
        idle(2);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_out", word_out, 32'd0);
        check("rst_word_last", 32'(word_last), 32'd0);
        check("rst_byte_num", 32'(word_byte_num), 32'd0);
        check("rst_msg_done", 32'(msg_done), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(s_ready), 32'd1);
        idle(1);

        // Short message: one partial last word
        expect_word(32'h6162_6300, 1'b1, 2'd3);
        send_str("abc", 1'b1);
        idle(4);

        // Message ends on a word boundary: data word then pad word
        expect_word(32'h4865_6C6C, 1'b0, 2'd0);
        expect_word(32'h0000_0000, 1'b1, 2'd0);
        send_str("Hell", 1'b1);
        check("ready_low_pad_pending", 32'(s_ready), 32'd0);
        idle(4);

        // Backpressure on the first word, later bytes keep filling
        expect_word(32'h7061_7373, 1'b0, 2'd0);
        expect_word(32'h776F_7264, 1'b0, 2'd0);
        expect_word(32'h3132_3300, 1'b1, 2'd3);
        buffer_full = 1'b1;
        fork
            send_str("password123", 1'b1);
            begin
                int t = 0;
                while (!word_valid && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                check("ready_blocked_full", 32'(s_ready), 32'd0);
                buffer_full = 1'b0;
                #1;
                check("ready_recover", 32'(s_ready), 32'd1);
            end
        join
        idle(4);

        // Single byte on both lane orders
        le_en = 1'b1;
        expect_word(32'h2100_0000, 1'b1, 2'd1);
        send_str("!", 1'b1);
        le_en = 1'b0;
        idle(4);

        // Reset mid-word
        send_str("xy", 1'b0);
        reset = 1'b1;
        #1;
        check("rst1_word_valid", 32'(word_valid), 32'd0);
        check("rst1_word_out", word_out, 32'd0);
        idle(1);
        reset = 1'b0;
        idle(1);

        // Reset while a word is held by backpressure
        buffer_full = 1'b1;
        send_str("wxyz", 1'b0);
        check("held_before_reset", 32'(word_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("rst2_word_valid", 32'(word_valid), 32'd0);
        check("rst2_word_out", word_out, 32'd0);
        check("rst2_word_last", 32'(word_last), 32'd0);
        check("rst2_byte_num", 32'(word_byte_num), 32'd0);
        check("rst2_msg_done", 32'(msg_done), 32'd0);
        idle(1);
        reset       = 1'b0;
        buffer_full = 1'b0;
        idle(1);
        expect_word(32'h6162_6300, 1'b1, 2'd3);
        send_str("abc", 1'b1);
        idle(4);

        // Long continuous message, multiple of 4 bytes
        expect_word(32'h5468_6520, 1'b0, 2'd0);
        expect_word(32'h7175_6963, 1'b0, 2'd0);
        expect_word(32'h6B20_6272, 1'b0, 2'd0);
        expect_word(32'h6F77_6E20, 1'b0, 2'd0);
        expect_word(32'h666F_7820, 1'b0, 2'd0);
        expect_word(32'h6A75_6D70, 1'b0, 2'd0);
        expect_word(32'h7320_6F76, 1'b0, 2'd0);
        expect_word(32'h6572_2074, 1'b0, 2'd0);
        expect_word(32'h6865_206C, 1'b0, 2'd0);
        expect_word(32'h617A_7920, 1'b0, 2'd0);
        expect_word(32'h646F_672E, 1'b0, 2'd0);
        expect_word(32'h0000_0000, 1'b1, 2'd0);
        send_str("The quick brown fox jumps over the lazy dog.", 1'b1);

        for (int i = 0; i < 100 && sb.size() > 0; i++) idle(1);
        idle(4);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("le_word_count", 32'(le_words), 32'd1);
        check("le_done_count", 32'(le_dones), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
Name: keccak_byte_packer

Overview:
- Upstream feeder for the keccak core. Takes a byte stream with valid/ready handshake and last-byte marker.
- Packs the bytes into the core's 32-bit word interface: in, in_ready, is_last, byte_num.
- Honours the core's buffer_full backpressure.
- Generates the core's end-of-message convention: partial last word with byte count, or an extra all-zero last word when the message length is a multiple of 4.

Parameters:
- BIG_ENDIAN, 1, 1: first byte of a word goes to bits [31:24]; 0: first byte goes to bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  8  input byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  s_data is the final byte of the message.
- s_ready  out  1  byte accepted on a rising edge when s_valid && s_ready.
- buffer_full  in  1  from keccak; word not taken while high.
- word_out  out  32  drives keccak in.
- word_valid  out  1  drives keccak in_ready.
- word_last  out  1  drives keccak is_last.
- word_byte_num  out  2  drives keccak byte_num.
- msg_done  out  1  one-cycle pulse when the final word of a message is taken.

Behaviour:
- Reset (async, immediate): acc=0, cnt=0, pad_pending=0, word_valid=0, word_out=0, word_last=0, word_byte_num=0, msg_done=0. s_ready goes high once reset deasserts. Reset mid-word or mid-output discards all partial data.
- Internal state:
  - acc[31:0]: accumulator.
  - cnt[1:0]: bytes held in acc.
  - Output register: word_out, word_valid, word_last, word_byte_num.
  - pad_pending flag.
- take_out = word_valid && !buffer_full. The word is consumed at that edge.
- Byte acceptance (s_valid && s_ready):
  - Byte k (k=cnt) is written into acc lane k.
  - BIG_ENDIAN=1: lane k = bits [31-8k : 24-8k]. BIG_ENDIAN=0: lane k = bits [8k+7 : 8k].
- Word completion: the accepted byte has cnt==3, or s_last=1. On completion:
  - Output register loads acc including the new byte. Unfilled lanes are zero.
  - cnt returns to 0 and acc clears.
- Completion fields:
  - s_last with cnt in 0..2: word_last=1, word_byte_num=cnt+1 (1..3).
  - s_last with cnt==3: word_last=0, word_byte_num=0, pad_pending set.
  - cnt==3 without s_last: word_last=0, word_byte_num=0.
- Pad word: when pad_pending and the output register is empty or take_out this cycle:
  - Load word_out=0, word_last=1, word_byte_num=0. Clear pad_pending.
- s_ready = !pad_pending && !(word_valid && !take_out && (cnt==3 || s_last)).
  - This is a combinational path from buffer_full and s_last. Bytes 1–3 of the next word may be accepted while the previous word waits.
- Output register:
  - Holds word_out, word_last and word_byte_num stable while word_valid && buffer_full.
  - word_valid clears after take_out unless reloaded the same edge. Back-to-back words are allowed.
- Simultaneous take_out and completion: the new word replaces the taken one with no bubble.
- msg_done: registered pulse, high the cycle after take_out of a word with word_last=1.
- Latency: a completing byte accepted at edge N appears on word_out after edge N. The pad word appears the cycle after the preceding word is taken.
- A new message may begin immediately after the last byte. The packer does not reset keccak; system control must do so between messages.

Test Plan:
- Bytes "abc", s_last on 'c', buffer_full=0 -> one word 0x61626300, word_last=1, byte_num=3; msg_done pulse the next cycle.
- "Hell", s_last on 'l' -> word 0x48656C6C (last=0), next cycle 0x00000000 (last=1, byte_num=0); s_ready low while pad_pending.
- 8-byte "password" then "123" (last on '3') with buffer_full held high 3 cycles at the first word -> word_out stable at 0x70617373. s_ready drops after 3 further bytes, recovers when buffer_full falls. Words 0x70617373, 0x776F7264, 0x31323300 (byte_num=3, last=1), no loss or duplication.
- Single byte '!' with s_last -> 0x21000000, byte_num=1, last=1. BIG_ENDIAN=0 same stimulus -> 0x00000021.
- Assert reset after 2 bytes and again while word_valid && buffer_full -> all outputs 0 immediately. Next message "abc" yields exactly 0x61626300 with no stale bytes.
- Continuous s_valid over "The quick brown fox jumps over the lazy dog." (44 bytes), buffer_full=0 -> 11 data words then pad word (last=1, byte_num=0); first word 0x54686520; total 12 words.
